// File: rtl/config_shift_tx_pkg.sv
// Shared definitions for the serial configuration port transmitter.
// Holds the configuration word layout, the FSM state encoding and a packing helper.
package config_shift_tx_pkg;

    localparam int CFG_WIDTH = 33;

    // Configuration word field layout (bit offsets, inclusive)
    localparam int MAX_CTR_MSB    = 32;
    localparam int MAX_CTR_LSB    = 26;
    localparam int CTR_SELECT_MSB = 25;
    localparam int CTR_SELECT_LSB = 24;
    localparam int SCALING_MSB    = 23;
    localparam int SCALING_LSB    = 22;
    localparam int CI_OFFSET_MSB  = 21;
    localparam int CI_OFFSET_LSB  = 11;
    localparam int CR_OFFSET_MSB  = 10;
    localparam int CR_OFFSET_LSB  = 0;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_GAP   = 2'd2;
    localparam state_t ST_START = 2'd3;

    // Assemble a configuration word from its fields
    function automatic logic [CFG_WIDTH-1:0] pack_cfg(
        input logic [6:0]  max_ctr,
        input logic [1:0]  ctr_select,
        input logic [1:0]  scaling,
        input logic [10:0] ci_offset,
        input logic [10:0] cr_offset
    );
        return {max_ctr, ctr_select, scaling, ci_offset, cr_offset};
    endfunction

endpackage

// File: rtl/config_shift_tx.sv
// Serial configuration port transmitter: accepts a parallel word over valid/ready
// and shifts it out LSB-first on shift_data/shift_en, optionally followed by start_out.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   word_in, gap,         - word, inter-bit idle cycles, start request;
//   start_after             all sampled on accept
//   word_valid/word_ready - input handshake (ready only in IDLE)
//   shift_en, shift_data  - strobe and serial bit for the receiver shift register
//   start_out             - one-cycle render start pulse
//   busy, done            - activity flag and one-cycle completion pulse
module config_shift_tx
    import config_shift_tx_pkg::*;
#(
    parameter int WIDTH = CFG_WIDTH,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic [GAP_W-1:0] gap,
    input  logic             start_after,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             shift_en,
    output logic             shift_data,
    output logic             start_out,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [GAP_W-1:0] gap_reg;
    logic [GAP_W-1:0] gap_cnt;
    logic             start_flag;
    logic [BIT_W-1:0] bit_cnt;
    logic             accept;

    assign accept = word_valid & word_ready;

    // Outputs are registered: each branch sets the values that will be
    // visible during the cycle the FSM is entering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            gap_reg    <= '0;
            gap_cnt    <= '0;
            start_flag <= 1'b0;
            bit_cnt    <= '0;
            word_ready <= 1'b1;
            shift_en   <= 1'b0;
            shift_data <= 1'b0;
            start_out  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            start_out  <= 1'b0;
            shift_en   <= 1'b0;
            shift_data <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sreg       <= word_in;
                        gap_reg    <= gap;
                        start_flag <= start_after;
                        bit_cnt    <= '0;
                        state      <= ST_SHIFT;
                        shift_en   <= 1'b1;
                        shift_data <= word_in[0];
                        word_ready <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    sreg    <= sreg >> 1;
                    bit_cnt <= bit_cnt + BIT_ONE;
                    if (bit_cnt == LAST_BIT) begin
                        if (start_flag) begin
                            state     <= ST_START;
                            start_out <= 1'b1;
                        end else begin
                            state      <= ST_IDLE;
                            done       <= 1'b1;
                            word_ready <= 1'b1;
                            busy       <= 1'b0;
                        end
                    end else if (gap_reg == '0) begin
                        // Back-to-back strobe: next bit is the one
                        // that moves into sreg[0] on this edge.
                        shift_en   <= 1'b1;
                        shift_data <= sreg[1];
                    end else begin
                        gap_cnt <= gap_reg;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - GAP_ONE;
                    if (gap_cnt == GAP_ONE) begin
                        state      <= ST_SHIFT;
                        shift_en   <= 1'b1;
                        shift_data <= sreg[0];
                    end
                end
                ST_START: begin
                    state      <= ST_IDLE;
                    done       <= 1'b1;
                    word_ready <= 1'b1;
                    busy       <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    word_ready <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_shift_tx.sv
// Self-checking bench for config_shift_tx: directed and random transfers
// checked against a receiver model built from logged strobes and cycle arithmetic.
module tb_config_shift_tx;
    import config_shift_tx_pkg::*;

    localparam int W     = 33;
    localparam int LIMIT = 2000;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] word_in;
    logic [3:0]   gap;
    logic         start_after;
    logic         word_valid;
    logic         word_ready;
    logic         shift_en;
    logic         shift_data;
    logic         start_out;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Event logs: strobed bits with their cycle, done/start cycles, accept edges
    bit bits[$];
    int scyc[$];
    int dcyc[$];
    int tcyc[$];
    int acyc[$];

    config_shift_tx #(.WIDTH(W), .GAP_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .word_in(word_in),
        .gap(gap),
        .start_after(start_after),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .shift_en(shift_en),
        .shift_data(shift_data),
        .start_out(start_out),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (shift_en) begin
            bits.push_back(shift_data);
            scyc.push_back(cyc);
        end
        if (done) dcyc.push_back(cyc);
        if (start_out) tcyc.push_back(cyc);
        if (word_valid && word_ready && !reset) acyc.push_back(cyc + 1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Receiver model: a W-bit register shifting right, new bit entering at the MSB
    function automatic logic [W-1:0] rx_word(input int base);
        logic [W-1:0] r;
        bit b;
        r = '0;
        for (int i = 0; i < W; i++) begin
            b = (base + i < bits.size()) ? bits[base + i] : 1'b0;
            r = {b, r[W-1:1]};
        end
        return r;
    endfunction

    function automatic int timing_errs(input int base, input int k, input int g);
        int bad;
        bad = 0;
        for (int i = 0; i < W; i++) begin
            if (base + i >= scyc.size()) bad++;
            else if (scyc[base + i] != k + i * (g + 1)) bad++;
        end
        return bad;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        word_in     = W'({$urandom(), $urandom()});
        gap         = 4'($urandom_range(0, 15));
        start_after = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [W-1:0] w, input int g, input bit st, input string tag);
        int base;
        int nd;
        int nt;
        int na;
        int n;
        int k;
        int last;
        base = bits.size();
        nd   = dcyc.size();
        nt   = tcyc.size();
        na   = acyc.size();
        n = 0;
        while (!word_ready && n < LIMIT) begin
            tick();
            n++;
        end
        word_in     = w;
        gap         = 4'(g);
        start_after = st;
        word_valid  = 1'b1;
        tick();
        word_valid = 1'b0;
        scramble();
        n = 0;
        while (dcyc.size() == nd && n < LIMIT) begin
            tick();
            n++;
        end
        chk({tag, " done wait"}, 64'(n < LIMIT), 64'd1);
        repeat (3) tick();
        chk({tag, " accepts"}, 64'(acyc.size() - na), 64'd1);
        k    = (acyc.size() > na) ? acyc[na] : -1;
        last = k + (W - 1) * (g + 1);
        chk({tag, " strobes"}, 64'(bits.size() - base), 64'(W));
        chk({tag, " timing"}, 64'(timing_errs(base, k, g)), 64'd0);
        chk({tag, " span"}, 64'(scyc[scyc.size() - 1] - scyc[base] + 1),
            64'(W + (W - 1) * g));
        chk({tag, " word"}, 64'(rx_word(base)), 64'(w));
        chk({tag, " starts"}, 64'(tcyc.size() - nt), 64'(st));
        if (st) chk({tag, " start cyc"}, 64'(tcyc[nt]), 64'(last + 1));
        chk({tag, " dones"}, 64'(dcyc.size() - nd), 64'd1);
        chk({tag, " done cyc"}, 64'(dcyc[nd]), 64'(last + 1 + int'(st)));
        chk({tag, " idle"}, 64'({word_ready, busy}), 64'b10);
    endtask

    initial begin
        int base;
        int nd;
        int nt;
        int na;
        int n;
        logic [W-1:0] wa;
        logic [W-1:0] wb;

        reset      = 1'b1;
        word_valid = 1'b0;
        scramble();
        repeat (3) tick();
        chk("reset outputs",
            64'({word_ready, shift_en, shift_data, start_out, busy, done}),
            64'b100000);
        reset = 1'b0;
        tick();
        chk("idle ready", 64'({word_ready, busy}), 64'b10);

        send(33'h1_2345_6789, 0, 1'b0, "gap0");
        send(33'h0_AAAA_AAAA, 2, 1'b0, "gap2");
        send(pack_cfg(7'h55, 2'd2, 2'd1, 11'h3A5, 11'h0F0), 1, 1'b1, "start");
        send(33'h1_FFFF_FFFF, 15, 1'b1, "gapmax");

        // Back-to-back with word_valid held high throughout
        wa   = 33'h1_DEAD_BEEF;
        wb   = 33'h0_1357_9BDF;
        base = bits.size();
        nd   = dcyc.size();
        na   = acyc.size();
        word_in     = wa;
        gap         = 4'd0;
        start_after = 1'b0;
        word_valid  = 1'b1;
        tick();
        word_in = wb;
        gap     = 4'd1;
        n = 0;
        while (acyc.size() < na + 2 && n < LIMIT) begin
            tick();
            n++;
        end
        word_valid = 1'b0;
        n = 0;
        while (dcyc.size() < nd + 2 && n < LIMIT) begin
            tick();
            n++;
        end
        chk("b2b done wait", 64'(n < LIMIT), 64'd1);
        repeat (3) tick();
        chk("b2b accepts", 64'(acyc.size() - na), 64'd2);
        chk("b2b second accept", 64'(acyc[na + 1]), 64'(dcyc[nd] + 1));
        chk("b2b first strobe", 64'(scyc[base + W]), 64'(dcyc[nd] + 1));
        chk("b2b word a", 64'(rx_word(base)), 64'(wa));
        chk("b2b word b", 64'(rx_word(base + W)), 64'(wb));
        chk("b2b period", 64'(acyc[na + 1] - acyc[na]), 64'(W + 1));

        // Reset during strobe 10
        base = bits.size();
        nd   = dcyc.size();
        nt   = tcyc.size();
        word_in     = 33'h0_F0F0_F0F0;
        gap         = 4'd0;
        start_after = 1'b1;
        word_valid  = 1'b1;
        tick();
        word_valid = 1'b0;
        n = 0;
        while (bits.size() - base < 9 && n < LIMIT) begin
            tick();
            n++;
        end
        reset = 1'b1;
        tick();
        chk("rst shift_en", 64'(shift_en), 64'd0);
        chk("rst ready", 64'({word_ready, busy}), 64'b10);
        reset = 1'b0;
        repeat (40) tick();
        chk("rst strobes", 64'(bits.size() - base), 64'd10);
        chk("rst no done", 64'(dcyc.size() - nd), 64'd0);
        chk("rst no start", 64'(tcyc.size() - nt), 64'd0);
        send(33'h0_F0F0_F0F0, 0, 1'b1, "after rst");

        for (int i = 0; i < 6; i++) begin
            send(W'({$urandom(), $urandom()}), $urandom_range(0, 5),
                 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
